// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit.
// Size encodings, FSM states, address alignment helpers.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STORE  = 3'd2,
    S_RMW_RD = 3'd3,
    S_RMW_WR = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  // Widest supported address; callers cast in and out.
  function automatic logic [63:0] align_addr(
    input logic [63:0] a,
    input logic [1:0]  size
  );
    logic [63:0] r;
    r = a;
    unique case (size)
      SZ_BYTE: r = a;
      SZ_HALF: r[0] = 1'b0;
      default: r[1:0] = 2'b00;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a
  );
    unique case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a[0];
      SZ_WORD: return a != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane_mux.sv
// Load lane extraction/extension and store lane merge.
// Purely combinational; word/size decode shared by both paths.
module lsu_lane_mux
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [15:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = word[{lane, 3'b000} +: 8];
    h      = lane[1] ? word[31:16] : word[15:0];
    rdata  = word;
    merged = word;
    unique case (size)
      SZ_BYTE: begin
        rdata = {{24{sgn & b[7]}}, b};
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        rdata = {{16{sgn & h[15]}}, h};
        if (lane[1]) merged[31:16] = wdata;
        else         merged[15:0]  = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: byte/half/word access over a word-only memory.
// Define LSU_ALIGN_FAULT_EN to fault misaligned/illegal requests.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic              mem_read_en,
  output logic              mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state;
  logic [1:0]        size_q;
  logic [1:0]        lane_q;
  logic              sgn_q;
  logic [15:0]       wdata_q;
  logic              accept;
  logic              bad_req;
  logic [1:0]        eff_size;
  logic [ADDR_W-1:0] eff_addr;
  logic [ADDR_W-1:0] word_addr;
  logic [31:0]       ld_data;
  logic [31:0]       st_data;

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;

`ifdef LSU_ALIGN_FAULT_EN
  assign eff_size = req_size;
  assign eff_addr = req_addr;
  assign bad_req  = misaligned(req_size, req_addr[1:0]);
`else
  // Truncate instead of faulting; illegal size behaves as word.
  assign eff_size = (req_size == 2'b11) ? SZ_WORD : req_size;
  assign eff_addr = ADDR_W'(align_addr(64'(req_addr), eff_size));
  assign bad_req  = 1'b0;
  assign resp_fault = 1'b0;
`endif

  assign word_addr = ADDR_W'(align_addr(64'(eff_addr), SZ_WORD));

  // Reset gates enables so an interrupted RMW never writes.
  assign mem_read_en  = !rst &&
    (state == S_LOAD || state == S_RMW_RD);
  assign mem_write_en = !rst &&
    (state == S_STORE || state == S_RMW_WR);

  lsu_lane_mux u_lane_mux (
    .word   (mem_rdata),
    .lane   (lane_q),
    .size   (size_q),
    .sgn    (sgn_q),
    .wdata  (wdata_q),
    .rdata  (ld_data),
    .merged (st_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      size_q     <= SZ_BYTE;
      lane_q     <= 2'b00;
      sgn_q      <= 1'b0;
      wdata_q    <= '0;
`ifdef LSU_ALIGN_FAULT_EN
      resp_fault <= 1'b0;
`endif
    end else begin
      resp_valid <= 1'b0;
`ifdef LSU_ALIGN_FAULT_EN
      resp_fault <= 1'b0;
`endif
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            size_q  <= eff_size;
            lane_q  <= eff_addr[1:0];
            sgn_q   <= req_signed;
            wdata_q <= req_wdata[15:0];
            if (bad_req) begin
              state <= S_FAULT;
            end else begin
              mem_addr <= word_addr;
              if (!req_write) begin
                state <= S_LOAD;
              end else if (eff_size == SZ_WORD) begin
                mem_wdata <= req_wdata;
                state     <= S_STORE;
              end else begin
                state <= S_RMW_RD;
              end
            end
          end
        end
        S_LOAD: begin
          resp_valid <= 1'b1;
          resp_rdata <= ld_data;
          state      <= S_IDLE;
        end
        S_STORE: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          state      <= S_IDLE;
        end
        S_RMW_RD: begin
          mem_wdata <= st_data;
          state     <= S_RMW_WR;
        end
        S_RMW_WR: begin
          resp_valid <= 1'b1;
          resp_rdata <= '0;
          state      <= S_IDLE;
        end
`ifdef LSU_ALIGN_FAULT_EN
        S_FAULT: begin
          resp_valid <= 1'b1;
          resp_fault <= 1'b1;
          resp_rdata <= '0;
          state      <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model.
// Expectations follow LSU_ALIGN_FAULT_EN when it is defined.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_signed   (req_signed),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk)
    if (mem_write_en) mem[mem_addr[7:2]] <= mem_wdata;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_flt;
    int          exp_lat;
    int          exp_rdc;
    int          exp_wrc;
    logic [31:0] exp_word;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(
    input logic w, input logic [1:0] sz, input logic sg,
    input logic [31:0] a, input logic [31:0] wd,
    input logic [31:0] rd, input logic flt,
    input int lat, input int rdc, input int wrc,
    input logic [31:0] word
  );
    vec_t t;
    t.w = w; t.sz = sz; t.sg = sg; t.a = a; t.wd = wd;
    t.exp_rd = rd; t.exp_flt = flt; t.exp_lat = lat;
    t.exp_rdc = rdc; t.exp_wrc = wrc; t.exp_word = word;
    return t;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Called at a negedge with req_ready high; returns at the
  // negedge where resp_valid was seen (or after the budget).
  task automatic run(
    input  logic w, input logic [1:0] sz, input logic sg,
    input  logic [31:0] a, input logic [31:0] wd,
    output int lat, output int rdc, output int wrc,
    output logic [31:0] wa, output logic [31:0] rd,
    output logic flt
  );
    lat = 0; rdc = 0; wrc = 0;
    wa = '0; rd = '0; flt = 1'b0;
    req_valid = 1'b1; req_write = w; req_size = sz;
    req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_size = 2'b00; req_signed = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_read_en && rdc == 0) rdc = c;
      if (mem_write_en && wrc == 0) begin
        wrc = c;
        wa  = mem_addr;
      end
      if (resp_valid) begin
        lat = c;
        rd  = resp_rdata;
        flt = resp_fault;
        break;
      end
    end
  endtask

  initial begin
    int          lat, rdc, wrc;
    logic [31:0] wa, rd, saved;
    logic        flt;
    string       n;

    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[4] = 32'h8899AABB;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;

    // Byte/half/word loads and stores (hand-computed).
    v.push_back(mk(0, 2'b00, 1, 32'h11, 0, 32'hFFFFFFAA, 0, 2, 1, 0, 32'h8899AABB));
    v.push_back(mk(0, 2'b01, 0, 32'h12, 0, 32'h00008899, 0, 2, 1, 0, 32'h8899AABB));
    v.push_back(mk(0, 2'b10, 1, 32'h10, 0, 32'h8899AABB, 0, 2, 1, 0, 32'h8899AABB));
    v.push_back(mk(0, 2'b00, 0, 32'h10, 0, 32'h000000BB, 0, 2, 1, 0, 32'h8899AABB));
    v.push_back(mk(0, 2'b01, 1, 32'h12, 0, 32'hFFFF8899, 0, 2, 1, 0, 32'h8899AABB));
    v.push_back(mk(1, 2'b00, 0, 32'h13, 32'h55, 0, 0, 3, 1, 2, 32'h5599AABB));
    v.push_back(mk(0, 2'b10, 0, 32'h10, 0, 32'h5599AABB, 0, 2, 1, 0, 32'h5599AABB));
    v.push_back(mk(1, 2'b01, 0, 32'h16, 32'hFFFF1234, 0, 0, 3, 1, 2, 32'h12340000));
    v.push_back(mk(0, 2'b01, 1, 32'h16, 0, 32'h00001234, 0, 2, 1, 0, 32'h12340000));
    v.push_back(mk(1, 2'b10, 0, 32'h18, 32'hCAFEF00D, 0, 0, 2, 0, 1, 32'hCAFEF00D));
    v.push_back(mk(0, 2'b00, 1, 32'h1B, 0, 32'hFFFFFFCA, 0, 2, 1, 0, 32'hCAFEF00D));
    v.push_back(mk(0, 2'b00, 0, 32'h1A, 0, 32'h000000FE, 0, 2, 1, 0, 32'hCAFEF00D));
    v.push_back(mk(1, 2'b00, 0, 32'h18, 32'hABCDEF80, 0, 0, 3, 1, 2, 32'hCAFEF080));
`ifdef LSU_ALIGN_FAULT_EN
    v.push_back(mk(1, 2'b01, 0, 32'h11, 32'hBEEF, 0, 1, 2, 0, 0, 32'h5599AABB));
    v.push_back(mk(0, 2'b11, 0, 32'h10, 0, 0, 1, 2, 0, 0, 32'h5599AABB));
    v.push_back(mk(0, 2'b10, 0, 32'h13, 0, 0, 1, 2, 0, 0, 32'h5599AABB));
    v.push_back(mk(0, 2'b00, 0, 32'h13, 0, 32'h00000055, 0, 2, 1, 0, 32'h5599AABB));
`else
    v.push_back(mk(1, 2'b01, 0, 32'h11, 32'hBEEF, 0, 0, 3, 1, 2, 32'h5599BEEF));
    v.push_back(mk(0, 2'b11, 0, 32'h10, 0, 32'h5599BEEF, 0, 2, 1, 0, 32'h5599BEEF));
    v.push_back(mk(0, 2'b10, 0, 32'h13, 0, 32'h5599BEEF, 0, 2, 1, 0, 32'h5599BEEF));
    v.push_back(mk(0, 2'b01, 1, 32'h13, 0, 32'h00005599, 0, 2, 1, 0, 32'h5599BEEF));
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_wr_en", 32'(mem_write_en), 0);
    check("rst_rd_en", 32'(mem_read_en), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_fault", 32'(resp_fault), 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'(req_ready), 1);

    foreach (v[i]) begin
      run(v[i].w, v[i].sz, v[i].sg, v[i].a, v[i].wd,
          lat, rdc, wrc, wa, rd, flt);
      n = $sformatf("v%0d", i);
      check({n, "_lat"}, 32'(lat), 32'(v[i].exp_lat));
      check({n, "_rdata"}, rd, v[i].exp_rd);
      check({n, "_fault"}, 32'(flt), 32'(v[i].exp_flt));
      check({n, "_rd_cyc"}, 32'(rdc), 32'(v[i].exp_rdc));
      check({n, "_wr_cyc"}, 32'(wrc), 32'(v[i].exp_wrc));
      if (wrc != 0)
        check({n, "_wr_addr"}, wa, {v[i].a[31:2], 2'b00});
      check({n, "_mem"}, mem[v[i].a[7:2]], v[i].exp_word);
    end

    // Reset while the write half of a byte RMW is pending.
    saved = mem[4];
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
    req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h77;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("rmw_rd_en", 32'(mem_read_en), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rmw_rst_wr_en", 32'(mem_write_en), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rmw_rst_mem", mem[4], saved);
    check("rmw_rst_valid", 32'(resp_valid), 0);
    check("rmw_rst_ready", 32'(req_ready), 1);
    @(negedge clk);
    check("rmw_rst_valid2", 32'(resp_valid), 0);
    check("rmw_rst_wr_en2", 32'(mem_write_en), 0);

    // Back-to-back: load accepted in the store's resp_valid cycle.
    run(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF,
        lat, rdc, wrc, wa, rd, flt);
    check("b2b_st_lat", 32'(lat), 2);
    check("b2b_ready", 32'(req_ready), 1);
    run(1'b0, 2'b10, 1'b0, 32'h20, 32'h0,
        lat, rdc, wrc, wa, rd, flt);
    check("b2b_ld_lat", 32'(lat), 2);
    check("b2b_ld_rdata", rd, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
